// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types, default widths and branch-target table for the program counter
package pc_pkg;

  localparam int D_DEF     = 12;
  localparam int L_DEF     = 5;
  localparam int LUT_DEPTH = 2 ** L_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  // Absolute jump/branch targets; narrower counters use the low bits of each entry.
  localparam logic [D_DEF-1:0] BR_LUT [LUT_DEPTH] = '{
    12'h000, 12'h008, 12'h014, 12'h040,
    12'h004, 12'h100, 12'h0ff, 12'hffe,
    12'h200, 12'h00a, 12'h333, 12'h07f,
    12'h400, 12'h555, 12'h0aa, 12'hfff,
    12'h011, 12'h022, 12'h033, 12'h044,
    12'h055, 12'h066, 12'h077, 12'h088,
    12'h099, 12'h0bb, 12'h0cc, 12'h0dd,
    12'h0ee, 12'h123, 12'h456, 12'h789
  };

endpackage

// File: rtl/branch_lut.sv
// rtl/branch_lut.sv - combinational index-to-target lookup into the branch-target table
module branch_lut
  import pc_pkg::*;
#(
  parameter int D = D_DEF,
  parameter int L = L_DEF
) (
  input  logic [L-1:0] idx,
  output logic [D-1:0] target
);

  logic [L_DEF-1:0] lut_idx;

  assign lut_idx = L_DEF'(idx);
  assign target  = D'(BR_LUT[lut_idx]);

endmodule

// File: rtl/prog_ctr_unit.sv
// rtl/prog_ctr_unit.sv - program counter with run/halt FSM, stall, LUT jumps/branches and rollover flag
module prog_ctr_unit
  import pc_pkg::*;
#(
  parameter int D = D_DEF,
  parameter int L = L_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic         halt,
  input  logic         jump_en,
  input  logic         branch_en,
  input  logic         branch_taken,
  input  logic [L-1:0] target_idx,
  output logic [D-1:0] prog_ctr,
  output logic         done,
  output logic         wrapped
);

  pc_state_e    state;
  pc_state_e    state_nxt;
  logic [D-1:0] pc_nxt;
  logic         done_nxt;
  logic         wrapped_nxt;
  logic [D-1:0] lut_target;
  logic         redirect;
  logic         pc_at_max;

  branch_lut #(
    .D(D),
    .L(L)
  ) u_branch_lut (
    .idx    (target_idx),
    .target (lut_target)
  );

  assign redirect  = jump_en | (branch_en & branch_taken);
  assign pc_at_max = (prog_ctr == {D{1'b1}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      prog_ctr <= '0;
      done     <= 1'b0;
      wrapped  <= 1'b0;
    end else begin
      state    <= state_nxt;
      prog_ctr <= pc_nxt;
      done     <= done_nxt;
      wrapped  <= wrapped_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (halt)  state_nxt = HALT;
      HALT:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Priority in RUN: halt > stall > jump/taken branch > increment.
  always_comb begin
    pc_nxt      = prog_ctr;
    done_nxt    = done;
    wrapped_nxt = wrapped;
    case (state)
      IDLE: begin
        pc_nxt   = '0;
        done_nxt = 1'b0;
        if (start) wrapped_nxt = 1'b0;
      end
      RUN: begin
        if (halt) begin
          done_nxt = 1'b1;
        end else if (stall) begin
          pc_nxt = prog_ctr;
        end else if (redirect) begin
          pc_nxt = lut_target;
        end else begin
          pc_nxt = prog_ctr + D'(1);
          if (pc_at_max) wrapped_nxt = 1'b1;
        end
      end
      HALT: begin
        if (start) begin
          pc_nxt      = '0;
          done_nxt    = 1'b0;
          wrapped_nxt = 1'b0;
        end
      end
      default: begin
        pc_nxt      = '0;
        done_nxt    = 1'b0;
        wrapped_nxt = 1'b0;
      end
    endcase
  end

endmodule
